// File: rtl/bound_flasher_if.sv
// bound_flasher_if -- handshake bundle between the flick pushbutton side and
// the bound flasher.
//   flick : start / kickback request (already synchronised to clk)
//   led   : N-lamp LED bar, led[i]=1 lights lamp i
//   busy  : flasher is running a sequence
//   done  : one-cycle pulse when a sequence returns to idle
// Modports: master = button/board side, slave = flasher.
interface bound_flasher_if #(
   parameter int N = 16
) ();
   logic         flick;
   logic [N-1:0] led;
   logic         busy;
   logic         done;

   modport master (output flick, input led, busy, done);
   modport slave  (input flick, output led, busy, done);
endinterface

// File: rtl/bound_flasher_gen.sv
// bound_flasher_gen -- parametrised LED bar flasher. The bar shows a
// thermometer code of L lit lamps and sweeps through the bound sequence
// 0 -> N -> B1 -> B2 -> 0 -> N -> 0, one lamp per tick (every TICK_DIV clks).
// A flick while UP1/UP3 sit on B1 or B2 kicks the bar back down to 0, after
// which that up-phase restarts.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : bound_flasher_if.slave (flick in; led, busy, done out)
// Optional feature: define BOUND_FLASHER_BLINK_EN to append BLINK_CNT on/off
// blinks of the whole bar after the final sweep down.
module bound_flasher_gen #(
   parameter int N         = 16,
   parameter int B1        = 5,
   parameter int B2        = 10,
   parameter int TICK_DIV  = 1,
   parameter int BLINK_CNT = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   bound_flasher_if.slave bus
);
   localparam int LW = $clog2(N + 1);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [LW-1:0] L_N      = LW'(N);
   localparam logic [LW-1:0] L_B1     = LW'(B1);
   localparam logic [LW-1:0] L_B2     = LW'(B2);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
`ifdef BOUND_FLASHER_BLINK_EN
   localparam int BW = $clog2(2 * BLINK_CNT + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_CNT - 1);
`endif

   typedef enum logic [3:0] {
      IDLE, UP1, DN1, UP2, DN2, UP3, DN3, KICK
`ifdef BOUND_FLASHER_BLINK_EN
      , BLINK
`endif
   } state_t;

   state_t          state_q, state_d;
   state_t          ret_q, ret_d;
   logic [LW-1:0]   lit_q, lit_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            tick;
   logic [N-1:0]    led_w;
`ifdef BOUND_FLASHER_BLINK_EN
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic            blink_on_q, blink_on_d;
`endif

   // Lit count each phase heads for.
   function automatic logic [LW-1:0] target(state_t s);
      case (s)
         UP1, UP3: target = L_N;
         DN1:      target = L_B1;
         UP2:      target = L_B2;
         default:  target = '0;
      endcase
   endfunction

   // Phase that follows once the target has been reached.
   function automatic state_t advance(state_t s);
      case (s)
         UP1:     advance = DN1;
         DN1:     advance = UP2;
         UP2:     advance = DN2;
         DN2:     advance = UP3;
         UP3:     advance = DN3;
`ifdef BOUND_FLASHER_BLINK_EN
         DN3:     advance = BLINK;
`else
         DN3:     advance = IDLE;
`endif
         default: advance = IDLE;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      lit_d   = lit_q;
      cnt_d   = cnt_q;
`ifdef BOUND_FLASHER_BLINK_EN
      bcnt_d     = bcnt_q;
      blink_on_d = blink_on_q;
`endif
      tick = (state_q != IDLE) && (cnt_q == CNT_LAST);

      if (state_q == IDLE) begin
         cnt_d = '0;
         if (bus.flick) begin
            state_d = UP1;
            lit_d   = '0;
         end
      end else begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick) begin
            case (state_q)
               UP1, UP3: begin
                  // Bounds are checked on the pre-step value of L.
                  if (bus.flick && (lit_q == L_B1 || lit_q == L_B2)) begin
                     ret_d = state_q;
                     lit_d = lit_q - 1'b1;
                     // With B1 == 1 the kick already lands on 0: stay in
                     // the up-phase so L never wraps below zero.
                     if (lit_d != '0) state_d = KICK;
                  end else begin
                     lit_d = lit_q + 1'b1;
                     if (lit_d == target(state_q)) state_d = advance(state_q);
                  end
               end
               UP2: begin
                  lit_d = lit_q + 1'b1;
                  if (lit_d == target(state_q)) state_d = advance(state_q);
               end
               DN1, DN2, DN3: begin
                  lit_d = lit_q - 1'b1;
                  if (lit_d == target(state_q)) state_d = advance(state_q);
               end
               KICK: begin
                  lit_d = lit_q - 1'b1;
                  if (lit_d == '0) state_d = ret_q;
               end
`ifdef BOUND_FLASHER_BLINK_EN
               BLINK: begin
                  blink_on_d = ~blink_on_q;
                  bcnt_d     = bcnt_q + 1'b1;
                  if (bcnt_q == BLINK_LAST) begin
                     state_d    = IDLE;
                     bcnt_d     = '0;
                     blink_on_d = 1'b0;
                  end
               end
`endif
               default: ;
            endcase
         end
      end

      busy_d = (state_d != IDLE);
      done_d = (state_q != IDLE) && (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ret_q   <= UP1;
         lit_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef BOUND_FLASHER_BLINK_EN
         bcnt_q     <= '0;
         blink_on_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         lit_q   <= lit_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef BOUND_FLASHER_BLINK_EN
         bcnt_q     <= bcnt_d;
         blink_on_q <= blink_on_d;
`endif
      end
   end

   // Thermometer decode: lamps below L are lit.
   always_comb begin
      led_w = '0;
      for (int i = 0; i < N; i++) led_w[i] = (i < int'(lit_q));
`ifdef BOUND_FLASHER_BLINK_EN
      if (state_q == BLINK) led_w = {N{blink_on_q}};
`endif
   end

   assign bus.led  = led_w;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_bound_flasher_gen.sv
module tb_bound_flasher_gen;
   localparam int NA = 16, B1A = 5, B2A = 10, TDA = 1;
   localparam int NB = 8,  B1B = 2, B2B = 5,  TDB = 3;
   localparam int BC = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n_a, rst_n_b;
   bound_flasher_if #(.N(NA)) bus_a ();
   bound_flasher_if #(.N(NB)) bus_b ();

   bound_flasher_gen #(.N(NA), .B1(B1A), .B2(B2A), .TICK_DIV(TDA), .BLINK_CNT(BC))
      dut_a (.clk(clk), .rst_n(rst_n_a), .bus(bus_a));
   bound_flasher_gen #(.N(NB), .B1(B1B), .B2(B2B), .TICK_DIV(TDB), .BLINK_CNT(BC))
      dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bus_b));

   int errors = 0;
   int checks = 0;

   // Reference model: position in the bound list plus lit count.
   // ph indexes the bound list {N, B1, B2, 0, N, 0}; ph==6 is the blink tail.
   typedef struct {
      bit act; int ph; int L; int cnt; bit kick; int bk; bit on; bit done;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mstep(mdl_t m, bit rst_n, bit flick,
                                  int n, int b1, int b2, int td, int bc);
      int tg;
      bit tk;
      m.done = 1'b0;
      if (!rst_n) begin
         m = '{default: 0};
         return m;
      end
      if (!m.act) begin
         if (flick) begin
            m.act = 1; m.ph = 0; m.L = 0; m.cnt = 0; m.kick = 0; m.bk = 0; m.on = 0;
         end
         return m;
      end
      tk = (m.cnt == td - 1);
      m.cnt = tk ? 0 : m.cnt + 1;
      if (!tk) return m;
      case (m.ph)
         0, 4:    tg = n;
         1:       tg = b1;
         2:       tg = b2;
         default: tg = 0;
      endcase
      if (m.ph == 6) begin
         m.bk++;
         m.on = ~m.on;
         if (m.bk == 2 * bc) begin
            m.act = 0; m.done = 1; m.on = 0; m.bk = 0;
         end
      end else if (m.kick) begin
         m.L--;
         if (m.L == 0) m.kick = 0;
      end else if ((m.ph == 0 || m.ph == 4) && flick && (m.L == b1 || m.L == b2)) begin
         m.L--;
         m.kick = (m.L != 0);
      end else begin
         m.L += (tg > m.L) ? 1 : -1;
         if (m.L == tg) begin
            m.ph++;
            if (m.ph == 6) begin
`ifdef BOUND_FLASHER_BLINK_EN
               m.bk = 0; m.on = 0;
`else
               m.act = 0; m.done = 1;
`endif
            end
         end
      end
      return m;
   endfunction

   function automatic logic [63:0] mled(mdl_t m, int n);
      if (m.act && m.ph == 6) return m.on ? ((64'd1 << n) - 64'd1) : 64'd0;
      return (64'd1 << m.L) - 64'd1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // One clock: advance models on the edge, compare both DUTs 1ns later.
   task automatic cyc();
      @(posedge clk);
      ma = mstep(ma, rst_n_a, bus_a.flick, NA, B1A, B2A, TDA, BC);
      mb = mstep(mb, rst_n_b, bus_b.flick, NB, B1B, B2B, TDB, BC);
      #1;
      chk("a.led",  64'(bus_a.led), mled(ma, NA));
      chk("a.busy", 64'(bus_a.busy), 64'(ma.act));
      chk("a.done", 64'(bus_a.done), 64'(ma.done));
      chk("b.led",  64'(bus_b.led), mled(mb, NB));
      chk("b.busy", 64'(bus_b.busy), 64'(mb.act));
      chk("b.done", 64'(bus_b.done), 64'(mb.done));
   endtask

   typedef struct {
      bit rst_n; bit flick; int n; logic [15:0] led; bit busy; bit done;
   } vec_t;
   vec_t vq[$];

   task automatic add(input bit r, input bit f, input int n,
                      input logic [15:0] led, input bit b, input bit d);
      vec_t v;
      v.rst_n = r; v.flick = f; v.n = n; v.led = led; v.busy = b; v.done = d;
      vq.push_back(v);
   endtask

   initial begin
      mdl_t p;
      bit found;
      ma = '{default: 0};
      mb = '{default: 0};
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      bus_a.flick = 1'b0; bus_b.flick = 1'b0;

      // Directed table for the default-sized flasher.
      add(0, 0, 1,  16'h0000, 0, 0);   // reset
      add(1, 0, 20, 16'h0000, 0, 0);   // stays idle
      add(1, 1, 1,  16'h0000, 1, 0);   // start: UP1, L=0
      add(1, 0, 16, 16'hFFFF, 1, 0);   // peak N
      add(1, 0, 11, 16'h001F, 1, 0);   // down to B1
      add(1, 0, 5,  16'h03FF, 1, 0);   // up to B2
      add(1, 0, 10, 16'h0000, 1, 0);   // down to 0
      add(1, 0, 16, 16'hFFFF, 1, 0);   // up to N
      add(1, 0, 15, 16'h0001, 1, 0);   // DN3, L=1
`ifdef BOUND_FLASHER_BLINK_EN
      add(1, 0, 1,  16'h0000, 1, 0);   // entering blink, tick 74
      add(1, 0, 1,  16'hFFFF, 1, 0);   // first blink on
      add(1, 0, 5,  16'h0000, 0, 1);   // tick 80: idle + done
`else
      add(1, 0, 1,  16'h0000, 0, 1);   // tick 74: idle + done
`endif
      add(1, 0, 1,  16'h0000, 0, 0);   // done is one cycle only
      add(1, 1, 1,  16'h0000, 1, 0);   // restart
      add(1, 0, 5,  16'h001F, 1, 0);   // UP1 at B1
      add(1, 1, 1,  16'h000F, 1, 0);   // kickback
      add(1, 0, 4,  16'h0000, 1, 0);   // KICK reaches 0, back to UP1
      add(1, 0, 16, 16'hFFFF, 1, 0);   // UP1 restarted to N
      add(1, 0, 4,  16'h0FFF, 1, 0);   // DN1 at L=12
      add(0, 0, 1,  16'h0000, 0, 0);   // mid-sequence reset
      add(1, 0, 1,  16'h0000, 0, 0);   // no done pulse after reset
      add(1, 1, 1,  16'h0000, 1, 0);   // new start
      add(1, 0, 16, 16'hFFFF, 1, 0);
      add(1, 0, 11, 16'h001F, 1, 0);   // UP2 entry at B1
      add(1, 1, 15, 16'h0000, 1, 0);   // flick held through UP2/DN2: ignored
      add(1, 0, 10, 16'h03FF, 1, 0);   // UP3 at B2
      add(1, 1, 1,  16'h01FF, 1, 0);   // kickback in UP3
      add(1, 0, 9,  16'h0000, 1, 0);
      add(1, 0, 16, 16'hFFFF, 1, 0);
`ifdef BOUND_FLASHER_BLINK_EN
      add(1, 0, 16, 16'h0000, 1, 0);
      add(1, 0, 6,  16'h0000, 0, 1);
`else
      add(1, 0, 16, 16'h0000, 0, 1);
`endif
      add(0, 0, 1,  16'h0000, 0, 0);

      cyc();                            // both DUTs reset
      rst_n_b = 1'b1;
      foreach (vq[i]) begin
         rst_n_a = vq[i].rst_n;
         bus_a.flick = vq[i].flick;
         repeat (vq[i].n) cyc();
         bus_a.flick = 1'b0;
         chk($sformatf("vec%0d.led", i),  64'(bus_a.led),  64'(vq[i].led));
         chk($sformatf("vec%0d.busy", i), 64'(bus_a.busy), 64'(vq[i].busy));
         chk($sformatf("vec%0d.done", i), 64'(bus_a.done), 64'(vq[i].done));
      end
      rst_n_a = 1'b1;

      // Prescaled, narrow instance: one step per 3 clocks.
      bus_b.flick = 1'b1; cyc(); bus_b.flick = 1'b0;
      repeat (2) cyc();
      chk("b.pre_2", 64'(bus_b.led), 64'h00);
      cyc();
      chk("b.pre_3", 64'(bus_b.led), 64'h01);
      repeat (21) cyc();
      chk("b.peak_n", 64'(bus_b.led), 64'hFF);
      found = 0;
      for (int k = 0; k < 500 && !found; k++) begin
         cyc();
         if (bus_b.done === 1'b1) found = 1;
      end
      chk("b.done_seen", 64'(found), 64'd1);

      // Flick on the exit edge is not a start; it must be seen in idle.
      bus_a.flick = 1'b1; cyc(); bus_a.flick = 1'b0;
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         p = mstep(ma, 1'b1, 1'b0, NA, B1A, B2A, TDA, BC);
         if (p.done) found = 1;
         else cyc();
      end
      chk("a.exit_reached", 64'(found), 64'd1);
      bus_a.flick = 1'b1;
      cyc();
      chk("a.exit_busy", 64'(bus_a.busy), 64'd0);
      chk("a.exit_done", 64'(bus_a.done), 64'd1);
      cyc();
      chk("a.idle_start", 64'(bus_a.busy), 64'd1);
      bus_a.flick = 1'b0;

      // Random flicks and occasional resets against the model.
      for (int k = 0; k < 4000; k++) begin
         bus_a.flick = ($urandom_range(0, 4) == 0);
         bus_b.flick = ($urandom_range(0, 4) == 0);
         rst_n_a = ($urandom_range(0, 299) != 0);
         rst_n_b = ($urandom_range(0, 299) != 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
